// File: rtl/motor_io_pkg.sv
// motor_io_pkg: register map and helpers shared by the motor I/O bank.
package motor_io_pkg;
  localparam logic [3:0] OFF_DUTY_F = 4'h0;
  localparam logic [3:0] OFF_DUTY_R = 4'h4;
  localparam logic [3:0] OFF_COUNT = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;
  localparam logic [11:0] OFF_PERIOD = 12'h100;
  localparam logic [11:0] OFF_CTRL = 12'h104;
  localparam int CH_STRIDE = 16;
  localparam int ERR_BIT = 0;
  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i+:8] = be[i] ? wdata[8*i+:8] : old[8*i+:8];
    return m;
  endfunction
endpackage

// File: rtl/motor_io_if.sv
// motor_io_if: PicoSoC iomem request/acknowledge bus.
interface motor_io_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  modport master(output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, input iomem_ready, iomem_rdata);
  modport slave(input iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, output iomem_ready, iomem_rdata);
endinterface

// File: rtl/quad_decoder.sv
// quad_decoder: synchronised 4x quadrature decoder with a loadable wrap-around counter.
module quad_decoder #(
  parameter int ENC_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             a,
  input  logic             b,
  input  logic             load,
  input  logic [ENC_W-1:0] load_val,
  output logic [ENC_W-1:0] count,
  output logic             err_pulse
);
  logic [1:0] s1_q, s2_q, prev_q;
  logic [ENC_W-1:0] count_q, count_d;
  logic up, dn;
  always_comb begin
    up = {prev_q, s2_q} inside {4'b0001, 4'b0111, 4'b1110, 4'b1000};
    dn = {prev_q, s2_q} inside {4'b0100, 4'b1101, 4'b1011, 4'b0010};
    err_pulse = (prev_q ^ s2_q) == 2'b11;
    count_d = load ? load_val : up ? count_q + ENC_W'(1) : dn ? count_q - ENC_W'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
      count_q <= '0;
    end else begin
      s1_q <= {a, b};
      s2_q <= s1_q;
      prev_q <= s2_q;
      count_q <= count_d;
    end
  end
  assign count = count_q;
endmodule

// File: rtl/motor_io_bank.sv
// motor_io_bank: iomem slave with NUM_CH shadowed, interlocked PWM pairs and quadrature counters.
module motor_io_bank
  import motor_io_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          PWM_W      = 16,
  parameter int          ENC_W      = 32,
  parameter logic [19:0] BASE       = 20'h03001,
  parameter int          PERIOD_RST = 1000
) (
  input  logic              clk,
  input  logic              resetn,
  motor_io_if.slave         bus,
  input  logic [NUM_CH-1:0] enc_a,
  input  logic [NUM_CH-1:0] enc_b,
  output logic [NUM_CH-1:0] pwm_fwd,
  output logic [NUM_CH-1:0] pwm_rev
);
  logic [11:0] off;
  logic sel, wr, ready_q, en_q, en_d, wrap;
  logic [31:0] rdata_q, rdata_d;
  logic [PWM_W-1:0] period_q, period_d, per, pcnt_q, pcnt_d;
  logic [PWM_W-1:0] duty_f_q [NUM_CH], duty_f_d [NUM_CH], duty_r_q [NUM_CH], duty_r_d [NUM_CH];
  logic [PWM_W-1:0] shf_q [NUM_CH], shr_q [NUM_CH];
  logic [NUM_CH-1:0] err_q, err_d, err_pulse, load, fwd_q, fwd_d, rev_q, rev_d;
  logic [ENC_W-1:0] count [NUM_CH], load_val [NUM_CH];
  assign off = bus.iomem_addr[11:0];
  assign sel = bus.iomem_valid && bus.iomem_addr[31:12] == BASE && !ready_q;
  assign wr = sel && bus.iomem_wstrb != 4'b0;
  assign per = period_q < PWM_W'(2) ? PWM_W'(2) : period_q;
  // >= rather than == so a PERIOD shrunk below the running count still wraps
  assign wrap = pcnt_q >= per - PWM_W'(1);
  assign pcnt_d = en_q && !wrap ? pcnt_q + PWM_W'(1) : '0;
  always_comb begin
    rdata_d = '0;
    period_d = period_q;
    en_d = en_q;
    if (off == OFF_PERIOD) begin
      rdata_d = 32'(period_q);
      if (wr) period_d = PWM_W'(merge_bytes(32'(period_q), bus.iomem_wdata, bus.iomem_wstrb));
    end
    if (off == OFF_CTRL) begin
      rdata_d = {31'b0, en_q};
      if (wr && bus.iomem_wstrb[0]) en_d = bus.iomem_wdata[0];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      duty_f_d[c] = duty_f_q[c];
      duty_r_d[c] = duty_r_q[c];
      load[c] = wr && off == 12'(c * CH_STRIDE) + 12'(OFF_COUNT);
      load_val[c] = ENC_W'(merge_bytes(32'(count[c]), bus.iomem_wdata, bus.iomem_wstrb));
      err_d[c] = err_pulse[c] || (err_q[c] && !(wr && off == 12'(c * CH_STRIDE) + 12'(OFF_STATUS)
                 && bus.iomem_wstrb[0] && bus.iomem_wdata[ERR_BIT]));
      fwd_d[c] = en_q && pcnt_q < shf_q[c] && shr_q[c] == '0;
      rev_d[c] = en_q && pcnt_q < shr_q[c] && shf_q[c] == '0;
      if (off == 12'(c * CH_STRIDE) + 12'(OFF_DUTY_F)) begin
        rdata_d = 32'(duty_f_q[c]);
        if (wr) duty_f_d[c] = PWM_W'(merge_bytes(32'(duty_f_q[c]), bus.iomem_wdata, bus.iomem_wstrb));
      end
      if (off == 12'(c * CH_STRIDE) + 12'(OFF_DUTY_R)) begin
        rdata_d = 32'(duty_r_q[c]);
        if (wr) duty_r_d[c] = PWM_W'(merge_bytes(32'(duty_r_q[c]), bus.iomem_wdata, bus.iomem_wstrb));
      end
      if (off == 12'(c * CH_STRIDE) + 12'(OFF_COUNT)) rdata_d = 32'(count[c]);
      if (off == 12'(c * CH_STRIDE) + 12'(OFF_STATUS)) rdata_d = 32'(err_q[c]) << ERR_BIT;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      period_q <= PWM_W'(PERIOD_RST);
      en_q <= 1'b0;
      pcnt_q <= '0;
      err_q <= '0;
      fwd_q <= '0;
      rev_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_f_q[c] <= '0;
        duty_r_q[c] <= '0;
        shf_q[c] <= '0;
        shr_q[c] <= '0;
      end
    end else begin
      ready_q <= sel;
      rdata_q <= sel ? rdata_d : '0;
      period_q <= period_d;
      en_q <= en_d;
      pcnt_q <= pcnt_d;
      err_q <= err_d;
      fwd_q <= fwd_d;
      rev_q <= rev_d;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_f_q[c] <= duty_f_d[c];
        duty_r_q[c] <= duty_r_d[c];
        if (!en_q || wrap) begin
          shf_q[c] <= duty_f_q[c];
          shr_q[c] <= duty_r_q[c];
        end
      end
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_dec
    quad_decoder #(.ENC_W(ENC_W)) u_dec (
      .clk(clk), .resetn(resetn), .a(enc_a[i]), .b(enc_b[i]), .load(load[i]),
      .load_val(load_val[i]), .count(count[i]), .err_pulse(err_pulse[i])
    );
  end
  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign pwm_fwd = fwd_q;
  assign pwm_rev = rev_q;
endmodule
